// File: rtl/spi_ctrl_pkg.sv
// SPI controller shared definitions: frame layout, FSM states and a
// small helper used to size the phase timer.
package spi_ctrl_pkg;

    localparam int FRAME_W  = 16;
    localparam int ADDR_W   = 7;
    localparam int DATA_W   = 8;
    localparam int RW_BIT   = 15;
    localparam int ADDR_MSB = 14;
    localparam int ADDR_LSB = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT_HI,
        ST_SHIFT_LO,
        ST_HOLD,
        ST_GAP
    } state_e;

    function automatic int max4(input int a, input int b,
                                input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/spi_ctrl_timer.sv
// Loadable down-counter that times every SPI phase; zero_o flags the last
// cycle of a phase. Ports: clk_i, rst_ni, load_i, load_val_i, zero_o.
module spi_ctrl_timer #(
    parameter int WIDTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 initiator: shifts one 16-bit frame {rw, addr, data} per
// valid/ready request, MSB first, and pulses done at the end of the gap.
// Ports: clk, rst_n, req_valid/req_ready/req_rw/req_addr/req_data,
// busy, done, rd_data, sclk, ncs, copi, cipo.
// Macro SPI_CONTROLLER_READBACK_EN enables read frames and rd_data capture.
module spi_controller
    import spi_ctrl_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_IDLE  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rd_data,
    output logic              sclk,
    output logic              ncs,
    output logic              copi,
    input  logic              cipo
);

    localparam int MAXV = max4(CLK_DIV, CS_SETUP, CS_HOLD, CS_IDLE);
    localparam int TW   = (MAXV > 1) ? $clog2(MAXV) : 1;

    localparam logic [TW-1:0] LD_SETUP = TW'(CS_SETUP - 1);
    localparam logic [TW-1:0] LD_HALF  = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0] LD_HOLD  = TW'(CS_HOLD - 1);
    localparam logic [TW-1:0] LD_IDLE  = TW'(CS_IDLE - 1);

    state_e               state_q, state_d;
    logic [FRAME_W-1:0]   shreg_q, shreg_d;
    logic [3:0]           bit_q, bit_d;
    logic [TW-1:0]        load_val;
    logic                 tmr_zero;
    logic                 accept;
    logic                 rw_bit;
    logic                 cs_active;

    // Ready also in the last gap cycle so back-to-back frames keep
    // exactly CS_IDLE cycles of ncs high.
    assign done      = (state_q == ST_GAP) && tmr_zero;
    assign req_ready = (state_q == ST_IDLE) || done;
    assign busy      = !req_ready;
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        unique case (state_q)
            ST_IDLE: ;
            ST_SETUP: begin
                if (tmr_zero) state_d = ST_SHIFT_HI;
            end
            ST_SHIFT_HI: begin
                if (tmr_zero) begin
                    bit_d = bit_q + 4'd1;
                    if (bit_q == 4'd15) begin
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_SHIFT_LO;
                        shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
                    end
                end
            end
            ST_SHIFT_LO: begin
                if (tmr_zero) state_d = ST_SHIFT_HI;
            end
            ST_HOLD: begin
                if (tmr_zero) state_d = ST_GAP;
            end
            ST_GAP: begin
                if (tmr_zero) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (accept) begin
            state_d = ST_SETUP;
            shreg_d = {rw_bit, req_addr, req_data};
            bit_d   = 4'd0;
        end
    end

    always_comb begin
        load_val = '0;
        unique case (state_d)
            ST_SETUP:    load_val = LD_SETUP;
            ST_SHIFT_HI: load_val = LD_HALF;
            ST_SHIFT_LO: load_val = LD_HALF;
            ST_HOLD:     load_val = LD_HOLD;
            ST_GAP:      load_val = LD_IDLE;
            default:     load_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
        end
    end

    // Reloaded on every state change so no phase can inherit a stale count.
    spi_ctrl_timer #(
        .WIDTH (TW)
    ) u_timer (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .load_i     (state_d != state_q),
        .load_val_i (load_val),
        .zero_o     (tmr_zero)
    );

    assign cs_active = (state_q == ST_SETUP) || (state_q == ST_SHIFT_HI) ||
                       (state_q == ST_SHIFT_LO) || (state_q == ST_HOLD);
    assign ncs  = !cs_active;
    assign sclk = (state_q == ST_SHIFT_HI);
    assign copi = cs_active && shreg_q[FRAME_W-1];

`ifdef SPI_CONTROLLER_READBACK_EN
    logic              rw_q;
    logic [DATA_W-1:0] rx_q;
    logic [DATA_W-1:0] rd_q;

    // cipo is taken on the edge that raises sclk; the last eight samples
    // are the data field. Loaded before the gap so it is valid with done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rw_q <= 1'b1;
            rx_q <= '0;
            rd_q <= '0;
        end else begin
            if (accept) rw_q <= req_rw;
            if (state_d == ST_SHIFT_HI && state_q != ST_SHIFT_HI) begin
                rx_q <= {rx_q[DATA_W-2:0], cipo};
            end
            if (state_q == ST_HOLD && state_d == ST_GAP && !rw_q) begin
                rd_q <= rx_q;
            end
        end
    end

    assign rw_bit  = req_rw;
    assign rd_data = rd_q;
`else
    logic unused_inputs;
    assign unused_inputs = ^{req_rw, cipo};
    assign rw_bit  = 1'b1;
    assign rd_data = '0;
`endif

endmodule
